// File: rtl/disp_scan_4dig_pkg.sv
// Shared constants and helpers for the 4-digit display scanner, decoder and top level.
package disp_scan_4dig_pkg;

    // All anodes released (active low).
    localparam logic [3:0] AN_OFF = 4'b1111;
    // Decoder enable deasserted: decoder drives all segments off.
    localparam logic SEG_EN_OFF = 1'b1;

    localparam int unsigned DEFAULT_SCAN_DIV = 50000;
    localparam int unsigned DEFAULT_DEAD     = 16;

    // One display slot as presented to the pins.
    typedef struct packed {
        logic [3:0] an_n;
        logic       en_n;
        logic [3:0] data;
    } slot_out_t;

    localparam slot_out_t SLOT_OFF = '{an_n: AN_OFF, en_n: SEG_EN_OFF, data: 4'h0};

    // Bit i set when digit i is a leading zero; digit 0 is never blanked.
    function automatic logic [3:0] lz_blank_mask(input logic [15:0] v);
        logic [3:0] m;
        m[0] = 1'b0;
        m[1] = (v[15:4] == 12'h000);
        m[2] = (v[15:8] == 8'h00);
        m[3] = (v[15:12] == 4'h0);
        return m;
    endfunction

endpackage

// File: rtl/disp_scan_4dig_scan_tick_gen.sv
// Slot counter (cnt) and digit index (idx) for the display scanner, with slot-phase flags.
module scan_tick_gen
    import disp_scan_4dig_pkg::*;
#(
    parameter int unsigned SCAN_DIV = DEFAULT_SCAN_DIV,
    parameter int unsigned DEAD     = DEFAULT_DEAD
) (
    input  logic       clk,
    input  logic       rst,
    output logic [1:0] idx,
    output logic       slot_start,
    output logic       dead_active,
    output logic       frame_end
);

    localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(SCAN_DIV - 1);
    localparam logic [CntW-1:0] CntDead = CntW'(DEAD);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic            slot_last;

    assign slot_last = (cnt_q == CntLast);

    // Next state: cnt wraps at the slot end and carries into idx (2-bit wrap 3 -> 0).
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (slot_last) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end
    end

    // Counter state; reset aborts any slot in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    // Phase flags decoded from the current state.
    always_comb begin
        idx         = idx_q;
        slot_start  = (cnt_q == '0);
        dead_active = (cnt_q < CntDead);
        frame_end   = slot_last && (idx_q == 2'd3);
    end

endmodule

// File: rtl/disp_scan_4dig.sv
// Four-digit multiplexed 7-segment scanner: tear-free value updates, leading-zero
// blanking and per-digit blinking. Outputs lag the (idx, cnt) state by one cycle.
module disp_scan_4dig
    import disp_scan_4dig_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = DEFAULT_SCAN_DIV, // >= 4
    parameter int unsigned DEAD         = DEFAULT_DEAD,     // < SCAN_DIV
    parameter int unsigned BLINK_FRAMES = 64                // >= 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic        load,
    input  logic        blank_lz,
    input  logic [3:0]  blink_mask,
    output logic [3:0]  digit_data,
    output logic        digit_en_n,
    output logic [3:0]  an_n,
    output logic        frame_done
);

    localparam int unsigned BcW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BcW-1:0] BcLast = BcW'(BLINK_FRAMES - 1);

    logic [1:0] idx;
    logic       slot_start;
    logic       dead_active;
    logic       frame_end;

    scan_tick_gen #(
        .SCAN_DIV (SCAN_DIV),
        .DEAD     (DEAD)
    ) u_tick (
        .clk         (clk),
        .rst         (rst),
        .idx         (idx),
        .slot_start  (slot_start),
        .dead_active (dead_active),
        .frame_end   (frame_end)
    );

    logic [15:0]    pend_val_q;
    logic           pend_flag_q;
    logic [15:0]    shown_val_q;
    logic           blink_ph_q;
    logic [BcW-1:0] blink_cnt_q;
    slot_out_t      slot_q, slot_d;
    logic           frame_done_q;
    logic [3:0]     blanked;

    // Double-buffered value: loads park in pend_*, the display only changes at a
    // frame boundary. A load on the boundary cycle itself waits for the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_val_q  <= 16'h0000;
            pend_flag_q <= 1'b0;
            shown_val_q <= 16'h0000;
        end else begin
            if (load) begin
                pend_val_q <= value;
            end
            if (load) begin
                pend_flag_q <= 1'b1;
            end else if (frame_end) begin
                pend_flag_q <= 1'b0;
            end
            if (frame_end && pend_flag_q) begin
                shown_val_q <= pend_val_q;
            end
        end
    end

    // Blink phase flips once every BLINK_FRAMES frame boundaries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
        end else if (frame_end) begin
            if (blink_cnt_q == BcLast) begin
                blink_cnt_q <= '0;
                blink_ph_q  <= ~blink_ph_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
        end
    end

    // Per-digit blank decision and next slot output.
    always_comb begin
        blanked = (blank_lz ? lz_blank_mask(shown_val_q) : 4'b0000)
                | (blink_ph_q ? blink_mask : 4'b0000);
        slot_d = SLOT_OFF;
        if (!dead_active && !blanked[idx]) begin
            slot_d.an_n = ~(4'b0001 << idx);
            slot_d.en_n = 1'b0;
            slot_d.data = shown_val_q[{idx, 2'b00} +: 4];
        end
    end

    // Registered pin outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q       <= SLOT_OFF;
            frame_done_q <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            frame_done_q <= frame_end;
        end
    end

    // Every slot must open in the dead window when one is configured.
    always_ff @(posedge clk) begin
        if (!rst && slot_start && (DEAD > 0)) begin
            assert (dead_active);
        end
    end

    assign an_n       = slot_q.an_n;
    assign digit_en_n = slot_q.en_n;
    assign digit_data = slot_q.data;
    assign frame_done = frame_done_q;

endmodule
